// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the read-side FIFO burst controller.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = 2;

    // True when one more pop can be issued without overrunning the output buffer.
    function automatic logic credit_ok(
        input logic [OCC_W-1:0] occ,
        input logic             inflight,
        input logic             pop
    );
        logic [OCC_W:0] sum_s;
        sum_s = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};
        return (sum_s < (OCC_W+1)'(BUF_DEPTH));
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order buffer that absorbs the FIFO read latency.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int M = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [M:0]       wdata,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [M:0]       head
);

    logic [M:0]       mem_r [BUF_DEPTH];
    logic             rd_ptr_r;
    logic             wr_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             pop_ok_s;
    logic             wr_ok_s;

    // A full buffer still accepts a write when the head leaves in the same cycle.
    always_comb begin
        pop_ok_s = pop & (occ_r != {OCC_W{1'b0}});
        wr_ok_s  = wr & ((occ_r != OCC_W'(BUF_DEPTH)) | pop_ok_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            occ_r    <= {OCC_W{1'b0}};
        end else begin
            if (wr_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({wr_ok_s, pop_ok_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign occ  = occ_r;
    assign head = mem_r[rd_ptr_r];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain burst controller: pops len words from the FIFO and streams them out.
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int M     = 7,
    parameter int LEN_W = 8
) (
    input  logic             r_clk,
    input  logic             r_reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             empty,
    input  logic [M:0]       dout,
    output logic             r_en,
    output logic             m_valid,
    output logic [M:0]       m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] rd_count
);

    rd_state_e        state_r;
    rd_state_e        state_nxt_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] issued_r;
    logic [LEN_W-1:0] rd_count_r;
    logic             inflight_r;
    logic [OCC_W-1:0] occ_s;
    logic             pop_s;
    logic             r_en_s;
    logic             last_issue_s;
    logic             busy_s;
    logic             done_s;

    rd_skid_buf #(.M(M)) u_buf (
        .clk   (r_clk),
        .rst_n (r_reset),
        .wr    (inflight_r),
        .wdata (dout),
        .pop   (pop_s),
        .occ   (occ_s),
        .head  (m_data)
    );

    assign m_valid = (occ_s != {OCC_W{1'b0}});
    assign pop_s   = m_valid & m_ready;

    // Pop request: only in RUN, with data available, words left and buffer credit.
    always_comb begin
        r_en_s = 1'b0;
        if (state_r == RUN) begin
            r_en_s = ~empty & (issued_r != len_r) & ~abort & credit_ok(occ_s, inflight_r, pop_s);
        end else begin
            r_en_s = 1'b0;
        end
        last_issue_s = r_en_s & ((issued_r + LEN_W'(1)) == len_r);
    end

    // State register.
    always_ff @(posedge r_clk or negedge r_reset) begin
        if (!r_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = (len != {LEN_W{1'b0}}) ? RUN : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_issue_s | abort) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if ((occ_s == {OCC_W{1'b0}}) && !inflight_r) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            RUN:     busy_s = 1'b1;
            DRAIN:   busy_s = 1'b1;
            DONE:    done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Burst length, issue/accept counters and the one-cycle read-latency flag.
    always_ff @(posedge r_clk or negedge r_reset) begin
        if (!r_reset) begin
            len_r      <= {LEN_W{1'b0}};
            issued_r   <= {LEN_W{1'b0}};
            rd_count_r <= {LEN_W{1'b0}};
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= r_en_s;
            if ((state_r == IDLE) && start) begin
                len_r      <= len;
                issued_r   <= {LEN_W{1'b0}};
                rd_count_r <= {LEN_W{1'b0}};
            end else begin
                if (r_en_s) begin
                    issued_r <= issued_r + LEN_W'(1);
                end
                if (pop_s) begin
                    rd_count_r <= rd_count_r + LEN_W'(1);
                end
            end
        end
    end

    assign r_en     = r_en_s;
    assign busy     = busy_s;
    assign done     = done_s;
    assign rd_count = rd_count_r;

endmodule
